if_fetch_queue: RTL

- Parametrised instruction-fetch front end: replaces the single-entry IF skid buffer with an N-entry in-order instruction queue plus up to MAX_OUTSTANDING pipelined SRAM-like fetch requests.
- Sits between the branch/exception redirect sources and the ID stage.
- Issues requests on the req/addr_ok/data_ok instruction SRAM interface and delivers {pc, inst, adef} to ID with a valid/allow_in handshake.
- Discards stale responses after any redirect.

---
 rtl/if_fetch_queue.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: an N-entry in-order instruction queue fed by
// up to MAX_OUTSTANDING pipelined requests on a req/addr_ok/data_ok SRAM port.
// Responses that belong to requests issued before a redirect are counted in
// cancel_cnt_reg and dropped when they return.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [31:0] ex_entry,
  input  logic [31:0] er_entry,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        id_allow_in,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_pc,
  output logic [31:0] if_to_id_inst,
  output logic        if_to_id_adef
);

  localparam int            PW       = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int            CW       = $clog2(IBUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(IBUF_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(IBUF_DEPTH);
  localparam logic [3:0]    MAX_C    = 4'(MAX_OUTSTANDING);

  // Queue storage, one slot per entry
  logic [31:0]           entry_pc_reg   [IBUF_DEPTH];
  logic [31:0]           entry_inst_reg [IBUF_DEPTH];
  logic [IBUF_DEPTH-1:0] entry_adef_reg;
  logic [IBUF_DEPTH-1:0] entry_filled_reg;

  // Fetch / queue control state
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [PW-1:0] fill_ptr_reg, fill_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [2:0]    outst_reg, outst_next;
  logic [2:0]    cancel_cnt_reg, cancel_cnt_next;
  logic          halted_reg, halted_next;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          misaligned;
  logic          has_room;
  logic [3:0]    in_flight;
  logic          push_req, push_adef, push, fill, drop, pop;
  logic [IBUF_DEPTH-1:0] alloc_sel, fill_sel;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fetch_pc_reg;

  assign if_to_id_pc   = entry_pc_reg[head_reg];
  assign if_to_id_inst = entry_inst_reg[head_reg];
  assign if_to_id_adef = entry_adef_reg[head_reg];

  // Handshake qualification: redirect priority, request gating, push/fill/pop
  always_comb begin
    redirect = excp_flush | ertn_flush | br_taken;
    if (excp_flush)      redirect_pc = ex_entry;
    else if (ertn_flush) redirect_pc = er_entry;
    else                 redirect_pc = br_target;

    misaligned = (fetch_pc_reg[1:0] != 2'b00);
    has_room   = (count_reg < DEPTH_C);
    in_flight  = {1'b0, cancel_cnt_reg} + {1'b0, outst_reg};

    // Occupancy here is pre-pop, so a full queue never allocates and pops together
    inst_sram_req = resetn & ~redirect & ~br_stall & ~halted_reg & ~misaligned & has_room
                    & ({1'b0, outst_reg} < MAX_C) & (in_flight < MAX_C);

    push_req  = inst_sram_req & inst_sram_addr_ok;
    push_adef = resetn & ~redirect & ~halted_reg & misaligned & has_room;
    push      = push_req | push_adef;

    // A response in a redirect cycle is swallowed by the cancel accounting
    drop = inst_sram_data_ok & ~redirect & (cancel_cnt_reg != 3'd0);
    fill = inst_sram_data_ok & ~redirect & (cancel_cnt_reg == 3'd0);

    if_to_id_valid = (count_reg != '0) & entry_filled_reg[head_reg];
    pop            = if_to_id_valid & id_allow_in & ~redirect;
  end

  // Per-entry write selects for allocation and fill
  genvar gi;
  generate
    for (gi = 0; gi < IBUF_DEPTH; gi++) begin : g_sel
      assign alloc_sel[gi] = push & (tail_reg == PW'(gi));
      assign fill_sel[gi]  = fill & (fill_ptr_reg == PW'(gi));
    end
  endgenerate

  // Next-state for pc, pointers and counters
  always_comb begin
    fetch_pc_next   = fetch_pc_reg;
    head_next       = head_reg;
    tail_next       = tail_reg;
    fill_ptr_next   = fill_ptr_reg;
    count_next      = count_reg;
    outst_next      = outst_reg;
    cancel_cnt_next = cancel_cnt_reg;
    halted_next     = halted_reg;
    if (redirect) begin
      fetch_pc_next   = redirect_pc;
      head_next       = '0;
      tail_next       = '0;
      fill_ptr_next   = '0;
      count_next      = '0;
      outst_next      = 3'd0;
      cancel_cnt_next = 3'(in_flight - {3'b000, inst_sram_data_ok});
      halted_next     = 1'b0;
    end else begin
      if (push_req)  fetch_pc_next = fetch_pc_reg + 32'd4;
      if (push_adef) halted_next   = 1'b1;
      if (push)      tail_next     = ptr_inc(tail_reg);
      // ADEF entries arrive pre-filled, so the fill pointer steps past them
      if (fill | push_adef) fill_ptr_next = ptr_inc(fill_ptr_reg);
      if (pop)       head_next     = ptr_inc(head_reg);
      count_next = count_reg + CW'(push) - CW'(pop);
      outst_next = outst_reg + 3'(push_req) - 3'(fill);
      if (drop) cancel_cnt_next = cancel_cnt_reg - 3'd1;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_reg   <= RESET_PC;
      head_reg       <= '0;
      tail_reg       <= '0;
      fill_ptr_reg   <= '0;
      count_reg      <= '0;
      outst_reg      <= 3'd0;
      cancel_cnt_reg <= 3'd0;
      halted_reg     <= 1'b0;
    end else begin
      fetch_pc_reg   <= fetch_pc_next;
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      fill_ptr_reg   <= fill_ptr_next;
      count_reg      <= count_next;
      outst_reg      <= outst_next;
      cancel_cnt_reg <= cancel_cnt_next;
      halted_reg     <= halted_next;
    end
  end

  // Queue entries: allocate at tail, fill at fill pointer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        entry_pc_reg[i]   <= 32'h0;
        entry_inst_reg[i] <= 32'h0;
      end
      entry_adef_reg   <= '0;
      entry_filled_reg <= '0;
    end else begin
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        if (alloc_sel[i]) begin
          entry_pc_reg[i]     <= fetch_pc_reg;
          entry_inst_reg[i]   <= 32'h0;
          entry_adef_reg[i]   <= push_adef;
          entry_filled_reg[i] <= push_adef;
        end else if (fill_sel[i]) begin
          entry_inst_reg[i]   <= inst_sram_rdata;
          entry_filled_reg[i] <= 1'b1;
        end
      end
    end
  end

  // Every response must belong to a live or cancelled request
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(inst_sram_data_ok && outst_reg == 3'd0 && cancel_cnt_reg == 3'd0));
    end
  end

endmodule
